// File: rtl/hfrv_mem_arbiter_if.sv
// Bus bundle between the CPU, the debug/loader master, the arbiter and the data memory.
// The slave modport is the arbiter view; the master modport is the requester/memory side.
interface hfrv_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              cpu_req;
  logic [BE_W-1:0]   cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic [BE_W-1:0]   dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/hfrv_mem_arbiter.sv
// Shares the HF-RISC data memory port between the CPU (priority) and a debug/loader master,
// with a starvation counter that forces a debug grant after STARVE_LIMIT denied cycles.
module hfrv_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  hfrv_mem_arbiter_if.slave   bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned LAT_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic              owner_dbg, owner_dbg_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;

  logic              cpu_win, dbg_win, rd_done;
  logic              cpu_stall, cpu_rvalid, dbg_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      owner_dbg  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      owner_dbg  <= owner_dbg_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Arbitration, memory mux, read return and starvation tracking; everything is quiet in reset.
  always_comb begin
    state_nxt      = state;
    lat_cnt_nxt    = lat_cnt;
    owner_dbg_nxt  = owner_dbg;
    starve_cnt_nxt = '0;
    cpu_win        = 1'b0;
    dbg_win        = 1'b0;
    rd_done        = 1'b0;
    cpu_stall      = 1'b0;
    cpu_rvalid     = 1'b0;
    dbg_rvalid     = 1'b0;
    cpu_rdata      = '0;
    dbg_rdata      = '0;
    mem_en         = 1'b0;
    mem_we         = '0;
    mem_addr       = '0;
    mem_wdata      = '0;

    if (!reset) begin
      case (state)
        IDLE: begin
          cpu_win = bus.cpu_req && !(bus.dbg_req && (starve_cnt == CNT_W'(STARVE_LIMIT)));
          dbg_win = bus.dbg_req && !cpu_win;
          if (cpu_win) begin
            mem_en    = 1'b1;
            mem_we    = bus.cpu_we;
            mem_addr  = bus.cpu_addr;
            mem_wdata = bus.cpu_wdata;
          end else if (dbg_win) begin
            mem_en    = 1'b1;
            mem_we    = bus.dbg_we;
            mem_addr  = bus.dbg_addr;
            mem_wdata = bus.dbg_wdata;
          end
          if (mem_en && (mem_we == '0)) begin
            state_nxt     = RD_WAIT;
            lat_cnt_nxt   = LAT_W'(RD_LATENCY);
            owner_dbg_nxt = dbg_win;
          end
        end
        RD_WAIT: begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            rd_done   = 1'b1;
            state_nxt = IDLE;
            if (owner_dbg) begin
              dbg_rvalid = 1'b1;
              dbg_rdata  = bus.mem_rdata;
            end else begin
              cpu_rvalid = 1'b1;
              cpu_rdata  = bus.mem_rdata;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase

      // A CPU read keeps the core stalled from its grant until the data-return cycle.
      cpu_stall = (bus.cpu_req && !cpu_win)
               || (cpu_win && (bus.cpu_we == '0))
               || ((state == RD_WAIT) && !owner_dbg && !rd_done);

      if (bus.dbg_req && !dbg_win) begin
        starve_cnt_nxt = (starve_cnt == CNT_W'(STARVE_LIMIT)) ? starve_cnt
                                                               : starve_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.cpu_gnt    = cpu_win;
  assign bus.dbg_gnt    = dbg_win;
  assign bus.cpu_stall  = cpu_stall;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dbg_rvalid = dbg_rvalid;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.dbg_rdata  = dbg_rdata;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Directed bench for hfrv_mem_arbiter: a transaction-level model with its own memory image
// predicts every output each cycle, and literal expectations pin the key scenarios.
module tb_hfrv_mem_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned LIMIT  = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  hfrv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  hfrv_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Memory device: strobe sampled mid-cycle, acted on at the rising edge.
  logic [31:0] tb_mem [logic [31:0]];
  logic [31:0] rd_pipe [RD_LAT];
  logic        s_en = 1'b0;
  logic [3:0]  s_we = '0;
  logic [31:0] s_addr = '0, s_wdata = '0;

  initial for (int i = 0; i < int'(RD_LAT); i++) rd_pipe[i] = '0;

  always @(negedge clk) begin
    s_en = bus.mem_en; s_we = bus.mem_we; s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
  end

  always @(posedge clk) begin
    if (s_en && s_we != 4'h0)
      tb_mem[s_addr] = merge(tb_mem.exists(s_addr) ? tb_mem[s_addr] : 32'h0, s_we, s_wdata);
    rd_pipe[0] <= (s_en && s_we == 4'h0) ? (tb_mem.exists(s_addr) ? tb_mem[s_addr] : 32'h0)
                                          : 32'h0;
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  // Transaction-level model: pending read (cycles to data, owner, data) plus denied-cycle count.
  logic [31:0] model_mem [logic [31:0]];
  int          rem = 0;
  int          starve = 0;
  logic        rd_dbg = 1'b0;
  logic [31:0] rd_data = '0;
  logic        m_cw, m_dw, m_en, m_stall, m_rvc, m_rvd;
  logic [3:0]  m_we;
  logic [31:0] m_addr, m_wd;

  always @(negedge clk) begin
    m_cw = 0; m_dw = 0; m_en = 0; m_stall = 0; m_rvc = 0; m_rvd = 0;
    m_we = '0; m_addr = '0; m_wd = '0;
    if (!reset) begin
      if (rem == 0) begin
        m_cw = bus.cpu_req && !(bus.dbg_req && starve >= int'(LIMIT));
        m_dw = bus.dbg_req && !m_cw;
        if (m_cw) begin
          m_en = 1; m_we = bus.cpu_we; m_addr = bus.cpu_addr; m_wd = bus.cpu_wdata;
        end else if (m_dw) begin
          m_en = 1; m_we = bus.dbg_we; m_addr = bus.dbg_addr; m_wd = bus.dbg_wdata;
        end
        m_stall = (bus.cpu_req && !m_cw) || (m_cw && bus.cpu_we == 4'h0);
      end else begin
        m_rvc   = (rem == 1) && !rd_dbg;
        m_rvd   = (rem == 1) && rd_dbg;
        m_stall = bus.cpu_req || (!rd_dbg && rem > 1);
      end
    end
    check("cyc cpu_gnt",    32'(bus.cpu_gnt),    32'(m_cw));
    check("cyc dbg_gnt",    32'(bus.dbg_gnt),    32'(m_dw));
    check("cyc cpu_stall",  32'(bus.cpu_stall),  32'(m_stall));
    check("cyc mem_en",     32'(bus.mem_en),     32'(m_en));
    check("cyc mem_we",     32'(bus.mem_we),     32'(m_we));
    check("cyc mem_addr",   bus.mem_addr,        m_addr);
    check("cyc mem_wdata",  bus.mem_wdata,       m_wd);
    check("cyc cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_rvc));
    check("cyc dbg_rvalid", 32'(bus.dbg_rvalid), 32'(m_rvd));
    check("cyc cpu_rdata",  bus.cpu_rdata,       m_rvc ? rd_data : 32'h0);
    check("cyc dbg_rdata",  bus.dbg_rdata,       m_rvd ? rd_data : 32'h0);
    if (reset) begin
      rem = 0; starve = 0;
    end else begin
      if (m_en && m_we != 4'h0) begin
        model_mem[m_addr] = merge(model_mem.exists(m_addr) ? model_mem[m_addr] : 32'h0,
                                  m_we, m_wd);
      end else if (m_en) begin
        rem = int'(RD_LAT); rd_dbg = m_dw;
        rd_data = model_mem.exists(m_addr) ? model_mem[m_addr] : 32'h0;
      end else if (rem > 0) begin
        rem--;
      end
      starve = (bus.dbg_req && !m_dw) ? ((starve < int'(LIMIT)) ? starve + 1 : starve) : 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cpu(input logic r, input logic [3:0] we, input logic [31:0] a,
                         input logic [31:0] d);
    bus.cpu_req = r; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic [3:0] we, input logic [31:0] a,
                         input logic [31:0] d);
    bus.dbg_req = r; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  task automatic dbg_write(input logic [31:0] a, input logic [31:0] d);
    set_dbg(1, 4'hF, a, d);
    @(negedge clk); check("preload dbg_gnt", 32'(bus.dbg_gnt), 32'h1);
    tick(); set_dbg(0, 4'h0, 32'h0, 32'h0);
  endtask

  int k;
  int dbg_cycle;

  initial begin
    reset = 1'b1;
    set_cpu(1, 4'hF, 32'h100, 32'h1);
    set_dbg(0, 4'h0, 32'h0, 32'h0);
    tick(); tick();
    @(negedge clk);
    check("rst cpu_gnt",   32'(bus.cpu_gnt),   32'h0);
    check("rst cpu_stall", 32'(bus.cpu_stall), 32'h0);
    check("rst mem_en",    32'(bus.mem_en),    32'h0);
    tick();
    reset = 1'b0;

    // CPU write then read-back of 0x100
    set_cpu(1, 4'hF, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    check("wr cpu_gnt",   32'(bus.cpu_gnt), 32'h1);
    check("wr mem_en",    32'(bus.mem_en),  32'h1);
    check("wr mem_we",    32'(bus.mem_we),  32'hF);
    check("wr mem_wdata", bus.mem_wdata,    32'hDEADBEEF);
    tick();
    set_cpu(1, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    check("rd cpu_gnt",      32'(bus.cpu_gnt),   32'h1);
    check("rd stall grant",  32'(bus.cpu_stall), 32'h1);
    tick();
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("rd stall +1",     32'(bus.cpu_stall),  32'h1);
    check("rd rvalid early", 32'(bus.cpu_rvalid), 32'h0);
    tick();
    @(negedge clk);
    check("rd cpu_rvalid",   32'(bus.cpu_rvalid), 32'h1);
    check("rd cpu_rdata",    bus.cpu_rdata,       32'hDEADBEEF);
    check("rd stall drop",   32'(bus.cpu_stall),  32'h0);
    tick();

    dbg_write(32'h200, 32'h12345678);
    dbg_write(32'h300, 32'h11223344);

    // Back-to-back CPU writes with a debug write pending
    set_dbg(1, 4'hF, 32'h400, 32'hCAFE0001);
    k = 0; dbg_cycle = 0;
    for (int c = 1; c <= 10; c++) begin
      set_cpu(1, 4'hF, 32'h500 + 32'(4 * k), 32'h5A5A0000 + 32'(k));
      @(negedge clk);
      if (bus.dbg_gnt && dbg_cycle == 0) dbg_cycle = c;
      if (bus.cpu_gnt) k++;
      if (c == 5) check("starve cpu_stall", 32'(bus.cpu_stall), 32'h1);
      if (c == 6) check("starve cnt clear", 32'(dut.starve_cnt), 32'h0);
      tick();
      if (dbg_cycle != 0) set_dbg(0, 4'h0, 32'h0, 32'h0);
    end
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    check("starve dbg_gnt cycle", 32'(dbg_cycle), 32'd5);
    check("starve cpu writes",    32'(k),         32'd9);

    // Debug read of 0x200 with the CPU idle
    set_dbg(1, 4'h0, 32'h200, 32'h0);
    @(negedge clk); check("drd dbg_gnt", 32'(bus.dbg_gnt), 32'h1);
    tick(); set_dbg(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); check("drd rvalid early", 32'(bus.dbg_rvalid), 32'h0);
    tick();
    @(negedge clk);
    check("drd dbg_rvalid", 32'(bus.dbg_rvalid), 32'h1);
    check("drd dbg_rdata",  bus.dbg_rdata,       32'h12345678);
    check("drd cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    tick();

    // Debug request held off by an outstanding CPU read
    set_cpu(1, 4'h0, 32'h100, 32'h0);
    @(negedge clk); check("hold cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    tick();
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    set_dbg(1, 4'hF, 32'h404, 32'hBEEF0404);
    @(negedge clk); check("hold dbg_gnt t1", 32'(bus.dbg_gnt), 32'h0);
    tick();
    @(negedge clk);
    check("hold cpu_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    check("hold dbg_gnt t2", 32'(bus.dbg_gnt),    32'h0);
    tick();
    @(negedge clk); check("hold dbg_gnt t3", 32'(bus.dbg_gnt), 32'h1);
    tick(); set_dbg(0, 4'h0, 32'h0, 32'h0);

    // Byte-lane write into 0x300
    set_cpu(1, 4'h2, 32'h300, 32'h0000AB00);
    @(negedge clk); check("bw cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    tick();
    set_cpu(1, 4'h0, 32'h300, 32'h0);
    @(negedge clk); tick();
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); tick();
    @(negedge clk);
    check("bw cpu_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    check("bw cpu_rdata",  bus.cpu_rdata,       32'h1122AB44);
    tick();

    // CPU grant and debug request in the same cycle
    set_cpu(1, 4'hF, 32'h700, 32'h1);
    set_dbg(1, 4'hF, 32'h704, 32'h2);
    @(negedge clk); check("sim cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    tick(); set_cpu(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("sim starve_cnt", 32'(dut.starve_cnt), 32'h1);
    check("sim dbg_gnt",    32'(bus.dbg_gnt),    32'h1);
    tick(); set_dbg(0, 4'h0, 32'h0, 32'h0);

    // Reset during an outstanding read
    set_cpu(1, 4'h0, 32'h200, 32'h0);
    @(negedge clk); check("rr cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    tick();
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rr cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
      check("rr cpu_rdata",  bus.cpu_rdata,       32'h0);
      check("rr cpu_stall",  32'(bus.cpu_stall),  32'h0);
      tick();
    end
    reset = 1'b0;
    set_cpu(1, 4'hF, 32'h600, 32'h600D600D);
    @(negedge clk); check("rr regrant", 32'(bus.cpu_gnt), 32'h1);
    tick(); set_cpu(0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("rr no rvalid", 32'(bus.cpu_rvalid), 32'h0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, got running, expected finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/hfrv_mem_arbiter.md
# hfrv_mem_arbiter

Two-port arbiter that shares the single HF-RISC data memory port between the CPU core and a debug/loader master (program preload, memory inspection). The CPU has priority. A starvation counter guarantees the debug master forward progress. Only one transaction is outstanding at a time. The block sits between the core and the memory model inside the DUT top.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- RD_LATENCY, 1, memory read latency in cycles after the issue cycle (legal 1..4)
- STARVE_LIMIT, 4, consecutive denied cycles after which the debug master wins (legal 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU request; held with addr/we/wdata until cpu_gnt
- cpu_we  in  DATA_W/8  byte write enables; 0 = read
- cpu_addr  in  ADDR_W  address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  request accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt, or CPU read outstanding
- cpu_rvalid  out  1  read data valid pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_rvalid
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  same as CPU  debug master request
- dbg_gnt, dbg_rvalid  out  1  debug grant / read valid
- dbg_rdata  out  DATA_W  debug read data
- mem_en  out  1  memory access strobe
- mem_we  out  DATA_W/8  byte enables to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  valid RD_LATENCY cycles after the mem_en read cycle

## Operation
- FSM states:
  - IDLE: grants are combinational.
  - RD_WAIT: a read is outstanding. Latency counter runs from RD_LATENCY down to 1.
- IDLE arbitration:
  - Only cpu_req → CPU granted.
  - Only dbg_req → debug granted.
  - Both, and starve_cnt < STARVE_LIMIT → CPU granted.
  - Both, and starve_cnt == STARVE_LIMIT → debug granted.
- Grant cycle:
  - gnt is high for the winner only.
  - mem_en=1; mem_we/addr/wdata are muxed from the winner.
  - If we≠0: the write completes in this cycle and the FSM stays IDLE.
  - If we==0: FSM → RD_WAIT, and the owner bit records the winner.
- RD_WAIT:
  - No grants; mem_en=0.
  - The counter decrements each cycle.
  - On the cycle the counter reads 1, mem_rdata is valid: the owner's rvalid=1 and rdata=mem_rdata (combinational pass-through). FSM → IDLE on the next edge.
- starve_cnt (4 bits):
  - +1 each cycle dbg_req=1 and dbg_gnt=0, saturating at STARVE_LIMIT.
  - Cleared on dbg_gnt, or when dbg_req=0.
- Idle mux values:
  - When not granting: mem_we=0, mem_addr=0, mem_wdata=0.
  - rdata outputs are 0 when their rvalid is 0.
- Requesters must not change addr/we/wdata while req=1 and gnt=0. Dropping req before gnt is allowed (request withdrawn).

## Timing
- Reset values: all gnt/rvalid/stall/mem_en = 0; mem_we/addr/wdata = 0; rdata = 0; FSM IDLE; starve_cnt 0.
- cpu_stall during reset: 0.
- Write: gnt and mem_en in cycle T. Next request can be granted at T+1, so write throughput is 1/cycle.
- Read: issue at T; rvalid at T+RD_LATENCY; next grant at the earliest T+RD_LATENCY+1. Read throughput is 1 per RD_LATENCY+1 cycles.
- cpu_stall stays high from a CPU read grant through its rvalid cycle, and drops in the rvalid cycle.
- Requests arriving during RD_WAIT are held off and counted toward starvation (debug only).
- Reset mid-read: the outstanding read is dropped, no rvalid is produced, and the FSM is IDLE on the cycle after reset deasserts.
- Simultaneous dbg_req rise and CPU grant: the counter becomes 1 at the next edge.

## Test plan
- Parameters RD_LATENCY=2, STARVE_LIMIT=4 unless noted.
- CPU write addr 0x100, we=0xF, data 0xDEADBEEF:
  - cpu_gnt and mem_en in the same cycle, mem_we=0xF.
  - A CPU read of 0x100 next cycle returns 0xDEADBEEF with cpu_rvalid 2 cycles after its grant.
  - cpu_stall is high for the grant cycle plus 1.
- Back-to-back CPU writes for 10 cycles with dbg_req held high:
  - dbg_gnt occurs in cycle 5 (after 4 denied cycles).
  - starve_cnt returns to 0.
  - The CPU is stalled exactly that cycle.
- Debug read of 0x200 (preloaded 0x12345678) while the CPU is idle: dbg_gnt at T, dbg_rvalid at T+2 with 0x12345678; cpu_rvalid stays 0.
- CPU read outstanding and dbg_req asserted: no grant in the RD_WAIT cycles; dbg_gnt in the cycle after cpu_rvalid.
- Byte write we=0x2, data 0x0000AB00 to a word holding 0x11223344: a read returns 0x1122AB44.
- Reset asserted in the cycle after a read grant: no rvalid ever appears; after reset all outputs are 0 and a new CPU request is granted in its first cycle.
